// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the interrupt/reset vector sequencer.
//   irq_state_t : sequencer FSM states
//   irq_mode_t  : which event the current sequence is servicing
//   DEF_*       : default vector addresses and stack page
//   P_BIT_*     : status-byte bit positions overridden on push
package irq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_H,
    ST_PUSH_L,
    ST_PUSH_P,
    ST_VEC_L,
    ST_VEC_H,
    ST_LOAD
  } irq_state_t;

  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_NMI,
    MODE_IRQ,
    MODE_BRK
  } irq_mode_t;

  localparam logic [15:0] DEF_NMI_VECTOR   = 16'hFFFA;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;
  localparam logic [7:0]  DEF_STACK_PAGE   = 8'h01;

  localparam int P_BIT_B      = 4;
  localparam int P_BIT_UNUSED = 5;

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI falling-edge detector with sticky pending flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   nmi        : raw active-low NMI line (sampled every cycle, ignores RDY)
//   clr        : clears the pending flag (sequence accepted the NMI)
//   pending    : an unserviced falling edge has been seen
module nmi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi,
  input  logic clr,
  output logic pending
);

  logic nmi_q;
  logic nmi_fall;

  assign nmi_fall = nmi_q & ~nmi;

  // A new edge coinciding with the clear wins, so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_q   <= 1'b1;
      pending <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (nmi_fall) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_vector_sequencer.sv
// Interrupt/reset vector sequencer. At an instruction boundary it arbitrates
// NMI > IRQ > BRK, then owns the bus to push PCH, PCL and P onto the stack
// page, fetch the two-byte vector and hand the core a new PC/SP plus an
// I-flag set strobe. Out of reset it runs the same sequence with dummy
// stack reads and the reset vector.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   RDY             low = stall; all state and outputs hold
//   NMI, IRQ        active-low interrupt lines (NMI edge, IRQ level)
//   insn_boundary   core is at the last cycle of an instruction
//   brk_req         BRK decoded (qualified by insn_boundary)
//   i_flag          current I flag
//   pc_in, p_in,
//   sp_in           return PC, status byte, stack pointer from the core
//   DATA_IN         bus read data
//   busy            sequencer owns ADDRESS/DATA_OUT/RW
//   ADDRESS, DATA_OUT, RW   bus outputs (RW: 1 = read)
//   pc_out/pc_load, sp_out/sp_load, set_i   one-cycle hand-off to the core
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | bus released, waiting for an accepted boundary
// ST_PUSH_H | push return PC high byte (dummy read in reset)
// ST_PUSH_L | push return PC low byte  (dummy read in reset)
// ST_PUSH_P | push status byte         (dummy read in reset)
// ST_VEC_L  | read vector low byte
// ST_VEC_H  | read vector high byte
// ST_LOAD   | present new PC/SP, strobe loads and set_i
module irq_vector_sequencer
  import irq_seq_pkg::*;
#(
  parameter int                         BUS_WIDTH     = 8,
  parameter int                         ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0]   NMI_VECTOR    = DEF_NMI_VECTOR,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = DEF_RESET_VECTOR,
  parameter logic [ADDRESS_WIDTH-1:0]   IRQ_VECTOR    = DEF_IRQ_VECTOR,
  parameter logic [BUS_WIDTH-1:0]       STACK_PAGE    = DEF_STACK_PAGE
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      RDY,
  input  logic                      NMI,
  input  logic                      IRQ,
  input  logic                      insn_boundary,
  input  logic                      brk_req,
  input  logic                      i_flag,
  input  logic [ADDRESS_WIDTH-1:0]  pc_in,
  input  logic [BUS_WIDTH-1:0]      p_in,
  input  logic [BUS_WIDTH-1:0]      sp_in,
  input  logic [BUS_WIDTH-1:0]      DATA_IN,
  output logic                      busy,
  output logic [ADDRESS_WIDTH-1:0]  ADDRESS,
  output logic [BUS_WIDTH-1:0]      DATA_OUT,
  output logic                      RW,
  output logic [ADDRESS_WIDTH-1:0]  pc_out,
  output logic                      pc_load,
  output logic [BUS_WIDTH-1:0]      sp_out,
  output logic                      sp_load,
  output logic                      set_i
);

  irq_state_t                state_q, state_d;
  irq_mode_t                 mode_q,  mode_d;
  logic [BUS_WIDTH-1:0]      sp_q,    sp_d;
  logic [ADDRESS_WIDTH-1:0]  pc_q,    pc_d;
  logic [BUS_WIDTH-1:0]      lo_q,    lo_d;
  logic [BUS_WIDTH-1:0]      hi_q,    hi_d;

  logic                      nmi_pending;
  logic                      nmi_clr;
  logic                      is_reset;
  logic [ADDRESS_WIDTH-1:0]  vector;
  logic [ADDRESS_WIDTH-1:0]  stack_addr;
  logic [BUS_WIDTH-1:0]      p_byte;

  nmi_edge_detect u_nmi_edge_detect (
    .clk     (CLK),
    .rst_n   (RST_N),
    .nmi     (NMI),
    .clr     (nmi_clr),
    .pending (nmi_pending)
  );

  assign is_reset   = (mode_q == MODE_RESET);
  assign stack_addr = {STACK_PAGE, sp_q};

  always_comb begin
    case (mode_q)
      MODE_NMI:   vector = NMI_VECTOR;
      MODE_RESET: vector = RESET_VECTOR;
      default:    vector = IRQ_VECTOR;
    endcase
  end

  always_comb begin
    p_byte               = p_in;
    p_byte[P_BIT_UNUSED] = 1'b1;
    p_byte[P_BIT_B]      = (mode_q == MODE_BRK);
  end

  // Everything is gated by RDY so a stall freezes the whole sequence,
  // including strobes; only the NMI edge detector keeps sampling.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_PUSH_H;
      mode_q  <= MODE_RESET;
      sp_q    <= '0;
      pc_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else if (RDY) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sp_q    <= sp_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sp_d     = sp_q;
    pc_d     = pc_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    nmi_clr  = 1'b0;
    busy     = 1'b1;
    ADDRESS  = '0;
    DATA_OUT = '0;
    RW       = 1'b1;
    pc_out   = '0;
    sp_out   = '0;
    pc_load  = 1'b0;
    sp_load  = 1'b0;
    set_i    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (insn_boundary && RDY) begin
          if (nmi_pending) begin
            mode_d  = MODE_NMI;
            nmi_clr = 1'b1;
            state_d = ST_PUSH_H;
          end else if (!IRQ && !i_flag) begin
            mode_d  = MODE_IRQ;
            state_d = ST_PUSH_H;
          end else if (brk_req) begin
            mode_d  = MODE_BRK;
            state_d = ST_PUSH_H;
          end
          if (state_d == ST_PUSH_H) begin
            sp_d = sp_in;
            pc_d = pc_in;
          end
        end
      end

      ST_PUSH_H: begin
        ADDRESS  = stack_addr;
        RW       = is_reset;
        DATA_OUT = is_reset ? '0 : pc_q[ADDRESS_WIDTH-1:BUS_WIDTH];
        sp_d     = sp_q - BUS_WIDTH'(1);
        state_d  = ST_PUSH_L;
      end

      ST_PUSH_L: begin
        ADDRESS  = stack_addr;
        RW       = is_reset;
        DATA_OUT = is_reset ? '0 : pc_q[BUS_WIDTH-1:0];
        sp_d     = sp_q - BUS_WIDTH'(1);
        state_d  = ST_PUSH_P;
      end

      ST_PUSH_P: begin
        ADDRESS  = stack_addr;
        RW       = is_reset;
        DATA_OUT = is_reset ? '0 : p_byte;
        sp_d     = sp_q - BUS_WIDTH'(1);
        state_d  = ST_VEC_L;
      end

      ST_VEC_L: begin
        ADDRESS = vector;
        lo_d    = DATA_IN;
        state_d = ST_VEC_H;
      end

      ST_VEC_H: begin
        ADDRESS = vector + ADDRESS_WIDTH'(1);
        hi_d    = DATA_IN;
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        pc_out  = {hi_q, lo_q};
        sp_out  = sp_q;
        pc_load = 1'b1;
        sp_load = 1'b1;
        set_i   = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/irq_vector_sequencer.md
# irq_vector_sequencer

Parametrised interrupt/reset sequencer for the tinymos6502 core. It arbitrates RESET, NMI, IRQ and BRK at instruction boundaries, and while doing so owns the external bus. For the duration of an event it:
- pushes PCH, PCL and P onto the stack page,
- fetches the two-byte vector,
- hands the core a new PC, SP and an I-flag set pulse.

It generalises the fixed count-only program-counter flow of the current core to a width-, vector- and stack-page-configurable, RDY-aware multi-cycle sequence.

## Interface
Parameters:
- BUS_WIDTH, 8, data width; ADDRESS_WIDTH must equal 2*BUS_WIDTH
- ADDRESS_WIDTH, 16, address width
- NMI_VECTOR, 16'hFFFA, NMI vector low-byte address
- RESET_VECTOR, 16'hFFFC, reset vector low-byte address
- IRQ_VECTOR, 16'hFFFE, IRQ/BRK vector low-byte address
- STACK_PAGE, 8'h01, high address byte for stack accesses

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous, active-low reset
- RDY  in  1  low = stall; all state and outputs hold
- NMI  in  1  active-low, falling-edge triggered
- IRQ  in  1  active-low, level
- insn_boundary  in  1  core is at the last cycle of an instruction
- brk_req  in  1  BRK opcode decoded, qualified by insn_boundary
- i_flag  in  1  current I flag
- pc_in  in  ADDRESS_WIDTH  return address to push
- p_in  in  BUS_WIDTH  status byte to push (B/bit5 overridden)
- sp_in  in  BUS_WIDTH  current stack pointer
- DATA_IN  in  BUS_WIDTH  read data
- busy  out  1  sequencer owns ADDRESS/DATA_OUT/RW
- ADDRESS  out  ADDRESS_WIDTH  bus address while busy
- DATA_OUT  out  BUS_WIDTH  write data
- RW  out  1  1 = read, 0 = write
- pc_out  out  ADDRESS_WIDTH  vector target
- pc_load  out  1  one-cycle load strobe for pc_out
- sp_out  out  BUS_WIDTH  updated stack pointer
- sp_load  out  1  one-cycle load strobe for sp_out
- set_i  out  1  one-cycle strobe to set the I flag

## Operation
- States: IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, LOAD. Mode register: RESET, NMI, IRQ or BRK.
- NMI edge detector:
  - NMI is registered every cycle, including while RDY is low.
  - A 1→0 transition sets nmi_pending.
  - nmi_pending clears on entry to PUSH_H in NMI mode.
  - An edge arriving mid-sequence stays pending.
- Arbitration happens in IDLE when insn_boundary=1 and RDY=1. Priority: NMI pending > IRQ low with i_flag=0 > brk_req.
  - Winner: mode is latched, internal SP is loaded from sp_in, return PC is loaded from pc_in, and the state goes to PUSH_H.
- PUSH_H, PUSH_L, PUSH_P:
  - ADDRESS={STACK_PAGE, SP}; SP decrements (wraps mod 2^BUS_WIDTH) after each.
  - DATA_OUT = PC high byte, PC low byte, then the P byte with bit5=1 and bit4 = (mode==BRK).
  - RW=0, except in RESET mode, where RW=1 (dummy reads) but SP still decrements.
- VEC_L and VEC_H:
  - ADDRESS = vector, then vector+1. Vector is NMI_VECTOR, RESET_VECTOR or IRQ_VECTOR (IRQ and BRK share it).
  - RW=1; DATA_IN is captured into lo, then hi.
- LOAD:
  - pc_out={hi,lo}, sp_out=SP.
  - pc_load=sp_load=set_i=1 for exactly one cycle; busy=1.
  - Next state IDLE.
- IDLE: busy=0, RW=1, DATA_OUT=0, ADDRESS=0, strobes=0.

## Timing
- Reset (RST_N low, asynchronous):
  - State=PUSH_H, mode=RESET, internal SP=8'h00, nmi_pending=0, NMI sample register=1.
  - busy=1, RW=1, ADDRESS={STACK_PAGE,8'h00}, DATA_OUT=0, pc_load=sp_load=set_i=0, pc_out=0, sp_out=0.
- After RST_N rises: the reset sequence runs. The final SP is 8'hFD; pc_load asserts in the 6th enabled cycle.
- Latency: boundary accepted in cycle N → PUSH_H in N+1 → pc_load in N+6 → IDLE in N+7, assuming RDY=1 throughout.
- RDY low: state, SP, captured bytes and all outputs freeze; strobes are held but counted once (the core qualifies them with RDY).
- insn_boundary while busy: ignored.
- IRQ deasserted before the boundary: not taken (level-sampled only at the boundary).
- RST_N low mid-sequence: immediate return to the reset values above; nmi_pending is lost.

## Structure
- Shared package irq_seq_pkg:
  - state enum irq_state_t
  - mode enum irq_mode_t
  - default vector and stack-page localparams
  - P-byte bit indices (B=4, unused=5)
- Sub-module nmi_edge_detect: sample register and pending flag, with set/clear inputs.

## Test plan
- Release reset with RDY=1, memory[FFFC]=34, [FFFD]=12 → three stack reads at 0100, 01FF, 01FE with RW=1; pc_out=1234 with pc_load on the 6th cycle; sp_out=FD.
- IRQ low, i_flag=0, sp_in=FD, pc_in=C005, p_in=20, boundary → writes 01FD=C0, 01FC=05, 01FB=20 (B=0); vector from FFFE; sp_out=FA; set_i pulses.
- brk_req, pc_in=8002 → same flow; pushed P has bit4=1; vector from FFFE.
- NMI falling edge during an IRQ sequence → the IRQ completes; at the next boundary NMI is taken from FFFA even with i_flag=1.
- RDY low for 3 cycles during PUSH_L → ADDRESS/DATA_OUT/RW are held; total latency grows by exactly 3.
- RST_N pulsed low during VEC_H of an NMI → outputs take reset values immediately, no pc_load; the reset sequence restarts.
